// File: rtl/muxn_arb_reg.sv
// N-channel registered multiplexer with valid/ready on every port.
// Channel choice is round-robin, fixed priority or external select, by MODE.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_EMPTY | output register holds no word, out_valid = 0
//   ST_FULL  | output register holds a word,  out_valid = 1
module muxn_arb_reg #(
    parameter int N    = 4,
    parameter int W    = 32,
    parameter int MODE = 0,
    parameter int SW   = 2
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [SW-1:0]   sel,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_sel
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_data;
    logic [SW-1:0]   r_sel;
    logic [SW-1:0]   r_ptr;

    logic            w_load_en;
    logic            w_found;
    logic            w_xfer;
    logic [SW-1:0]   w_gnt;
    logic [N-1:0]    w_gnt_oh;
    logic [W-1:0]    w_gnt_data;
    logic [SW-1:0]   w_ptr_nxt;
    logic [2*N-1:0]  w_vld_dbl;
    logic [N-1:0]    w_vld_rot;

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_data;
    assign out_sel   = r_sel;
    assign w_load_en = ~out_valid | out_ready;

    // Bit j of w_vld_rot is channel (ptr + j) mod N, so the first set bit is
    // the round-robin winner counted from the pointer.
    assign w_vld_dbl = {in_valid, in_valid} >> r_ptr;
    assign w_vld_rot = w_vld_dbl[N-1:0];

    always_comb begin : p_arb
        int v_idx;
        v_idx   = 0;
        w_found = 1'b0;
        w_gnt   = '0;
        if (MODE == 0) begin
            for (int i = 0; i < N; i++) begin
                if (!w_found && w_vld_rot[i]) begin
                    v_idx = int'(r_ptr) + i;
                    if (v_idx >= N) begin
                        v_idx = v_idx - N;
                    end
                    w_found = 1'b1;
                    w_gnt   = SW'(v_idx);
                end
            end
        end else if (MODE == 1) begin
            for (int i = 0; i < N; i++) begin
                if (!w_found && in_valid[i]) begin
                    w_found = 1'b1;
                    w_gnt   = SW'(i);
                end
            end
        end else begin
            // A select value of N or more matches no channel and grants nothing.
            for (int i = 0; i < N; i++) begin
                if (sel == SW'(i) && in_valid[i]) begin
                    w_found = 1'b1;
                    w_gnt   = SW'(i);
                end
            end
        end
    end

    assign w_xfer = w_found & w_load_en;

    always_comb begin
        w_gnt_data = '0;
        w_gnt_oh   = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt == SW'(i)) begin
                w_gnt_data  = in_data[i*W +: W];
                w_gnt_oh[i] = w_xfer;
            end
        end
    end

    // Ready is gated by reset so no handshake can complete while clrn is low.
    assign in_ready  = w_gnt_oh & {N{clrn}};
    assign w_ptr_nxt = (w_gnt == SW'(N-1)) ? '0 : w_gnt + SW'(1);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_xfer) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_xfer) begin
                    w_state_nxt = ST_FULL;
                end else if (out_ready) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_data <= '0;
            r_sel  <= '0;
            r_ptr  <= '0;
        end else if (w_xfer) begin
            r_data <= w_gnt_data;
            r_sel  <= w_gnt;
            if (MODE == 0) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

endmodule

// File: doc/muxn_arb_reg.md
Name: muxn_arb_reg

Overview:
- Parametrised N-channel, W-bit registered multiplexer with a valid/ready handshake on every input and on the output.
- Successor to the 2:1 transmission-gate mux: channel selection is made by an internal arbiter (round-robin or fixed priority) or by an external select.
- The chosen word is captured in a one-entry output register.
- Used wherever several producers share one datapath bus in the CPU/IO subsystem.

Parameters:
- N, 4, number of input channels (2..16).
- W, 32, data width per channel in bits.
- MODE, 0, selection mode: 0 round-robin, 1 fixed priority (lowest index wins), 2 manual (channel = sel).
- SW, 2, select/pointer width; must equal clog2(N).

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- clrn, in, 1, asynchronous active-low reset.
- in_data, in, N*W, packed input words; channel i occupies bits [i*W+W-1 : i*W].
- in_valid, in, N, per-channel valid.
- in_ready, out, N, per-channel ready; one-hot or zero.
- sel, in, SW, channel select; used only when MODE=2.
- out_data, out, W, registered output word.
- out_valid, out, 1, output register holds a word.
- out_ready, in, 1, downstream accepts out_data.
- out_sel, out, SW, index of the channel whose word is in out_data.

Behaviour:
- Reset: while clrn=0, out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0, and in_ready=0 (forced combinationally).
- Reset mid-operation: any buffered word is discarded and no transfer completes in that cycle.
- Output register states: EMPTY (out_valid=0) and FULL (out_valid=1).
- load_en = ~out_valid | out_ready.
- Grant is combinational from in_valid, ptr, sel and load_en. At most one in_ready bit is high, and only when load_en=1:
  - MODE 0: first channel with in_valid=1, searching from ptr upward, wrapping N-1 to 0.
  - MODE 1: lowest index with in_valid=1.
  - MODE 2: channel sel, if in_valid[sel]=1. If sel >= N, no grant.
- An input transfer occurs on in_valid[g] & in_ready[g].
- Output register update on a clock edge with a transfer:
  - out_data <= word of channel g, out_sel <= g, out_valid <= 1.
  - MODE 0 only: ptr <= (g==N-1) ? 0 : g+1.
- Output register update on a clock edge with no transfer:
  - If out_valid & out_ready, out_valid <= 0; out_data and out_sel hold their last values.
  - ptr is unchanged.
- State transitions:
  - EMPTY→FULL on a transfer.
  - FULL→EMPTY on out_ready with no transfer.
  - FULL→FULL on a simultaneous drain and load, giving back-to-back words at one word per cycle with no bubble.
- Latency: a word accepted at edge k appears on out_data/out_valid after edge k, i.e. one cycle.
- Stall: out_valid=1 & out_ready=0 → in_ready=0 for all channels; out_data, out_sel and ptr are held.
- No input valid → no grant, ptr unchanged.
- out_ready while EMPTY is ignored.
- Source rules: a producer holds in_valid and in_data stable until accepted. in_valid must not depend on in_ready. in_ready may depend on in_valid.
- MODE 2: changing sel while a channel is waiting is legal. The grant follows the current sel in each cycle.
- Fairness (MODE 0): with all N inputs continuously valid and out_ready=1, grants rotate 0,1,..,N-1,0,… Each channel gets exactly one grant per N transfers.
- No arithmetic beyond pointer increment; the pointer wraps modulo N for non-power-of-2 N.

Test Plan:
1. Reset: hold clrn=0 with all in_valid=1 → in_ready=0000, out_valid=0, out_data=0, out_sel=0. Assert clrn=0 while FULL → out_valid drops to 0 immediately (asynchronous).
2. Round-robin, N=4, W=32, MODE=0: all in_valid=1 with in_data[i]=32'hA0+i, out_ready=1 for 8 cycles → out_sel sequence 0,1,2,3,0,1,2,3; out_data 0xA0..0xA3 repeating; out_valid=1 every cycle after the first.
3. Back-pressure: FULL with out_data=0xA1, out_ready=0 for 3 cycles → in_ready=0000; out_data and out_sel hold; ptr stays at 2; next grant on release is channel 2.
4. Sparse and wrap: only in_valid[3] and in_valid[0] set, ptr=1 → grant 3, then grant 0 (pointer wraps), then ptr=1. With all in_valid=0 → out_valid falls to 0 after drain.
5. Fixed priority, MODE=1: in_valid=1110 continuously → channel 1 always granted; channels 2 and 3 starve, which is the required behaviour.
6. Manual, MODE=2, N=3, SW=2: sel=2 with in_valid=111 → only in_ready[2]=1, out_sel=2. sel=3 → in_ready=000 and out_valid drains to 0.
